mul_spi_master: RTL
===================

MUL_SPI_MASTER -- requirements
Module: mul_spi_master

Interface
REQ-001 Parameter NssPosition, default 0: index of the target multiplier's select bit in spi.nss.
REQ-002 Parameter TimeoutCycles, default 16: WAIT-state cycle budget when MUL_SPI_MASTER_TIMEOUT_EN is defined.
REQ-003 W SHALL equal REGISTER_SIZE from package Isa; the packet is MulPacket = {op_2, op_1}, 2W bits.
REQ-004 Ports SHALL be exactly as follows.
- i_clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  reset, asynchronous, active-low.
- i_valid  input  1  host requests a multiplication.
- o_ready  output  1  block is idle and accepts a request.
- i_op_1  input  W  first operand.
- i_op_2  input  W  second operand.
- o_done  output  1  one-cycle pulse; o_result and o_error are valid.
- o_result  output  W  low W bits of op_1*op_2, as returned by the slave.
- o_error  output  1  transaction aborted by timeout.
- spi  Spi.MasterSpi  -  drives nss and mosi, samples miso; all on i_clock, no serial clock.

Function
REQ-005 The FSM states SHALL be IDLE, SELECT, START, TX, WAIT, RX and DONE.
REQ-006 IDLE: o_ready=1, all nss bits 1, mosi=0; when i_valid=1 at an edge, latch {i_op_2,i_op_1} and go to SELECT.
REQ-007 SELECT (1 cycle): nss[NssPosition]=0, all other nss bits 1, mosi=0.
REQ-008 START (1 cycle): mosi=1 as the start bit.
REQ-009 TX (2W cycles): in the k-th TX cycle (k=0..2W-1), mosi=packet[k], LSB first, so op_1 bits are sent before op_2 bits.
REQ-010 WAIT: mosi=0; when miso=1 at an edge, go to RX; miso=0 or z keeps WAIT.
REQ-011 RX (W cycles): at the edge ending the j-th RX cycle, capture result[j]=miso.
REQ-012 DONE (1 cycle): o_done=1; o_result holds the captured word; all nss bits 1; then go to IDLE.
REQ-013 nss[NssPosition] SHALL stay 0 continuously from SELECT through RX.
REQ-014 o_ready SHALL be 0 outside IDLE; i_valid is ignored outside IDLE and the operands are not re-sampled.
REQ-015 With a conforming multiplier slave, WAIT SHALL last 2 cycles, and o_done SHALL assert in the cycle after the (3W+4)-th edge following the accept edge.
REQ-016 o_result SHALL hold its value until the next DONE or reset, and o_error SHALL clear at the next accept.
REQ-017 Arithmetic SHALL NOT be performed locally; the product width is W, truncated by the slave.

Reset
REQ-018 While i_reset=0, asynchronously: state IDLE, all nss bits 1, mosi=0, o_done=0, o_error=0, o_result=0, and internal counters and shift registers 0.
REQ-019 Reset during any state SHALL abort the transaction without a DONE pulse; the slave shares i_reset and returns to its receive state.

Configuration
REQ-020 With MUL_SPI_MASTER_TIMEOUT_EN defined:
- A counter SHALL count WAIT cycles.
- If TimeoutCycles cycles elapse without miso=1, the FSM SHALL go to DONE with o_error=1 and o_result=0.
REQ-021 Without MUL_SPI_MASTER_TIMEOUT_EN:
- WAIT SHALL persist indefinitely.
- o_error SHALL be tied to 0.
- No timeout counter SHALL be synthesized.

Verification (W=8, bench instantiates the multiplier slave at NssPosition=0)
REQ-022 op_1=3, op_2=5, i_valid pulsed:
- mosi = 1 (start), then 1,1,0,0,0,0,0,0, then 1,0,1,0,0,0,0,0.
- o_done after 28 edges with o_result=15 and o_error=0.
REQ-023 op_1=0xFF, op_2=0xFF -> o_result=0x01 (truncated 0xFE01).
REQ-024 Two back-to-back requests (7*9, then 0*200) with i_valid held high during the first:
- Second accepted only after DONE.
- Results 63, then 0.
- nss deasserted in DONE between the two transactions.
REQ-025 i_reset pulsed low in the 5th TX cycle:
- nss returns to all ones and mosi=0 immediately.
- No o_done.
- Next request 2*3 returns 6.
REQ-026 With the macro defined and no slave (miso forced 0):
- o_done with o_error=1 and o_result=0, 16 cycles after entering WAIT.
- Without the macro, the bench checks that the FSM is still in WAIT after 1000 cycles.

Source files
------------

// File: rtl/mul_spi_master_if.sv
// ISA constants and the single-clock serial bus shared by mul_spi_master and its multiplier slaves.
// The bus carries one active-low select per slave plus mosi/miso, all timed on the system clock.
package Isa;
  localparam int REGISTER_SIZE = 8;
  localparam int SPI_SLAVES    = 4;
endpackage

interface Spi;
  logic [Isa::SPI_SLAVES-1:0] nss;
  logic                       mosi;
  logic                       miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/mul_spi_master.sv
// Serial master that ships {op_2, op_1} to a remote multiplier and collects its W-bit product.
// Optional feature macro: MUL_SPI_MASTER_TIMEOUT_EN (bounded WAIT state with error reporting).
module mul_spi_master #(
  parameter int NssPosition   = 0,
  parameter int TimeoutCycles = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [Isa::REGISTER_SIZE-1:0] i_op_1,
  input  logic [Isa::REGISTER_SIZE-1:0] i_op_2,
  output logic                          o_done,
  output logic [Isa::REGISTER_SIZE-1:0] o_result,
  output logic                          o_error,
  Spi.MasterSpi                         spi
);

  localparam int W    = Isa::REGISTER_SIZE;
  localparam int PW   = 2 * W;
  localparam int NS   = Isa::SPI_SLAVES;
  localparam int CntW = $clog2(PW);

  localparam logic [NS-1:0]   NssIdle   = '1;
  localparam logic [NS-1:0]   NssSelect = ~(NS'(1) << NssPosition);
  localparam logic [CntW-1:0] TxLast    = CntW'(PW - 1);
  localparam logic [CntW-1:0] RxLast    = CntW'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    TX,
    WAIT,
    RX,
    DONE
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [PW-1:0]   packet_reg;
  logic [CntW-1:0] bit_cnt_reg;
  logic [W-2:0]    rx_reg;
  logic [W-1:0]    result_reg;
  logic            frame;
  logic            mosi_bit;

`ifdef MUL_SPI_MASTER_TIMEOUT_EN
  localparam int WaitW = $clog2(TimeoutCycles + 1);

  logic [WaitW-1:0] wait_cnt_reg;
  logic             error_reg;
  logic             timeout_hit;
`endif

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    frame      = 1'b0;
    mosi_bit   = 1'b0;
`ifdef MUL_SPI_MASTER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_next = SELECT;
        end
      end
      SELECT: begin
        frame      = 1'b1;
        state_next = START;
      end
      START: begin
        frame      = 1'b1;
        mosi_bit   = 1'b1;
        state_next = TX;
      end
      TX: begin
        frame    = 1'b1;
        mosi_bit = packet_reg[0];
        if (bit_cnt_reg == TxLast) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        frame = 1'b1;
        if (spi.miso == 1'b1) begin
          state_next = RX;
        end
`ifdef MUL_SPI_MASTER_TIMEOUT_EN
        else if (wait_cnt_reg == WaitW'(TimeoutCycles - 1)) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
`endif
      end
      RX: begin
        frame = 1'b1;
        if (bit_cnt_reg == RxLast) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select and data lines follow the state directly, so reset releases the slave at once.
  assign spi.nss  = frame ? NssSelect : NssIdle;
  assign spi.mosi = mosi_bit;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      packet_reg  <= '0;
      bit_cnt_reg <= '0;
      rx_reg      <= '0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          bit_cnt_reg <= '0;
          if (i_valid) begin
            packet_reg <= {i_op_2, i_op_1};
          end
        end
        TX: begin
          packet_reg  <= packet_reg >> 1;
          bit_cnt_reg <= (bit_cnt_reg == TxLast) ? '0 : bit_cnt_reg + 1'b1;
        end
        RX: begin
          // Received LSB first: W-1 bits settle in rx_reg, the last one goes straight to the result.
          rx_reg <= {spi.miso, rx_reg[W-2:1]};
          if (bit_cnt_reg == RxLast) begin
            result_reg  <= {spi.miso, rx_reg};
            bit_cnt_reg <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
`ifdef MUL_SPI_MASTER_TIMEOUT_EN
      if (timeout_hit) begin
        result_reg <= '0;
      end
`endif
    end
  end

`ifdef MUL_SPI_MASTER_TIMEOUT_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
      if (state_reg == IDLE && i_valid) begin
        error_reg <= 1'b0;
      end else if (timeout_hit) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign o_error = error_reg;
`else
  assign o_error = 1'b0;
`endif

  assign o_result = result_reg;

endmodule
